// File: rtl/vend_pkg.sv
// vend_pkg: shared coin values, change FSM states and coin selection encoding
package vend_pkg;
  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} chg_state_e;
  typedef enum logic [2:0] {SEL_NONE = 3'b000, SEL_5 = 3'b001, SEL_10 = 3'b010, SEL_25 = 3'b100} coin_sel_e;
  function automatic int coin_value(coin_sel_e s);
    return s == SEL_25 ? COIN_25 : s == SEL_10 ? COIN_10 : s == SEL_5 ? COIN_5 : 0;
  endfunction
endpackage

// File: rtl/coin_hopper.sv
// coin_hopper: one denomination's saturating inventory counter
module coin_hopper #(
  parameter int INV_W = 6,
  parameter int INIT  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [INV_W-1:0] cnt
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= INV_W'(INIT);
    else if (inc && !dec) cnt <= &cnt ? cnt : cnt + 1'b1;
    else if (dec && !inc) cnt <= cnt - 1'b1;
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out an owed amount greedily in 25/10/5 coins with inventory tracking
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W   = 7,
  parameter int INV_W   = 6,
  parameter int INIT_25 = 8,
  parameter int INIT_10 = 8,
  parameter int INIT_5  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  output logic             coin_out_25,
  output logic             coin_out_10,
  output logic             coin_out_5,
  input  logic             coin_ack,
  input  logic             refill_25,
  input  logic             refill_10,
  input  logic             refill_5,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remainder,
  output logic [INV_W-1:0] cnt_25,
  output logic [INV_W-1:0] cnt_10,
  output logic [INV_W-1:0] cnt_5
);
  chg_state_e state, state_nx;
  coin_sel_e sel, pick;
  logic [AMT_W-1:0] rem;
  logic taken;
  assign taken = state == ISSUE && coin_ack;
  always_comb begin
    pick = rem >= AMT_W'(COIN_25) && cnt_25 != '0 ? SEL_25 :
           rem >= AMT_W'(COIN_10) && cnt_10 != '0 ? SEL_10 :
           rem >= AMT_W'(COIN_5)  && cnt_5  != '0 ? SEL_5  : SEL_NONE;
  end
  coin_hopper #(.INV_W(INV_W), .INIT(INIT_25)) u_h25 (.clk, .reset_n, .inc(refill_25), .dec(taken && sel == SEL_25), .cnt(cnt_25));
  coin_hopper #(.INV_W(INV_W), .INIT(INIT_10)) u_h10 (.clk, .reset_n, .inc(refill_10), .dec(taken && sel == SEL_10), .cnt(cnt_10));
  coin_hopper #(.INV_W(INV_W), .INIT(INIT_5))  u_h5  (.clk, .reset_n, .inc(refill_5),  .dec(taken && sel == SEL_5),  .cnt(cnt_5));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? SELECT : IDLE;
      SELECT:  state_nx = pick != SEL_NONE ? ISSUE : DONE;
      ISSUE:   state_nx = coin_ack ? SELECT : ISSUE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem       <= '0;
      sel       <= SEL_NONE;
      done      <= 1'b0;
      short     <= 1'b0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && req_valid) begin
        rem       <= req_amount;
        short     <= 1'b0;
        remainder <= '0;
      end
      if (state == SELECT) begin
        sel <= pick;
        if (pick == SEL_NONE) begin
          done      <= 1'b1;
          short     <= rem != '0;
          remainder <= rem;
        end
      end
      if (taken) begin
        sel <= SEL_NONE;
        rem <= rem - AMT_W'(coin_value(sel));
      end
    end
  end
  always_comb begin
    req_ready   = state == IDLE;
    coin_out_25 = sel == SEL_25;
    coin_out_10 = sel == SEL_10;
    coin_out_5  = sel == SEL_5;
  end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of payout order, shortfall, handshake hold, refill and reset
module tb_change_dispenser;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, coin_ack = 1'b1;
  logic refill_25 = 1'b0, refill_10 = 1'b0, refill_5 = 1'b0;
  logic [6:0] req_amount = '0;
  logic a_ready, a_c25, a_c10, a_c5, a_done, a_short;
  logic [6:0] a_rem;
  logic [5:0] a_n25, a_n10, a_n5;
  logic b_ready, b_c25, b_c10, b_c5, b_done, b_short;
  logic [6:0] b_rem;
  logic [5:0] b_n25, b_n10, b_n5;
  logic use2 = 1'b0;
  logic o_ready, o_c25, o_c10, o_c5, o_done, o_short;
  logic [6:0] o_rem;
  logic [5:0] o_n25;
  int checks = 0, errors = 0;
  logic [31:0] seq;
  int lat;
  logic sh;
  logic [6:0] rm;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(a_ready), .req_amount(req_amount),
    .coin_out_25(a_c25), .coin_out_10(a_c10), .coin_out_5(a_c5), .coin_ack(coin_ack),
    .refill_25(refill_25), .refill_10(refill_10), .refill_5(refill_5),
    .done(a_done), .short(a_short), .remainder(a_rem), .cnt_25(a_n25), .cnt_10(a_n10), .cnt_5(a_n5));

  change_dispenser #(.INIT_5(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(b_ready), .req_amount(req_amount),
    .coin_out_25(b_c25), .coin_out_10(b_c10), .coin_out_5(b_c5), .coin_ack(coin_ack),
    .refill_25(refill_25), .refill_10(refill_10), .refill_5(refill_5),
    .done(b_done), .short(b_short), .remainder(b_rem), .cnt_25(b_n25), .cnt_10(b_n10), .cnt_5(b_n5));

  assign o_ready = use2 ? b_ready : a_ready;
  assign o_c25   = use2 ? b_c25   : a_c25;
  assign o_c10   = use2 ? b_c10   : a_c10;
  assign o_c5    = use2 ? b_c5    : a_c5;
  assign o_done  = use2 ? b_done  : a_done;
  assign o_short = use2 ? b_short : a_short;
  assign o_rem   = use2 ? b_rem   : a_rem;
  assign o_n25   = use2 ? b_n25   : a_n25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
  endtask

  // lat counts posedges after the accept edge until done is seen; coins are packed 8 bits each, first coin highest
  task automatic run_req(input int amt, output logic [31:0] s, output int l, output logic sh_o, output logic [6:0] rm_o);
    s = '0; l = -1; sh_o = 1'b0; rm_o = '0;
    @(negedge clk);
    chk("accept_ready", o_ready, 1);
    req_valid = 1'b1;
    req_amount = 7'(amt);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 60 && l < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (o_c25 + o_c10 + o_c5 > 1) chk("onehot", {o_c25, o_c10, o_c5}, 0);
      if (o_c25) s = {s[23:0], 8'd25};
      if (o_c10) s = {s[23:0], 8'd10};
      if (o_c5)  s = {s[23:0], 8'd5};
      if (o_done) begin
        l = k; sh_o = o_short; rm_o = o_rem;
      end
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_coins", {a_c25, a_c10, a_c5}, 0);
    chk("rst_done_short", {a_done, a_short}, 0);
    chk("rst_remainder", a_rem, 0);
    chk("rst_cnt", {a_n25, a_n10, a_n5}, {6'd8, 6'd8, 6'd8});
    reset_n = 1'b1;

    run_req(40, seq, lat, sh, rm);
    chk("t1_seq", seq, 32'h0019_0a05);
    chk("t1_lat", lat, 7);
    chk("t1_short_rem", {sh, rm}, 0);
    chk("t1_cnt", {a_n25, a_n10, a_n5}, {6'd7, 6'd7, 6'd7});

    run_req(0, seq, lat, sh, rm);
    chk("t2_seq", seq, 0);
    chk("t2_lat", lat, 1);
    chk("t2_short", sh, 0);

    do_reset();
    use2 = 1'b1;
    run_req(30, seq, lat, sh, rm);
    chk("t3_seq", seq, 32'h19);
    chk("t3_lat", lat, 3);
    chk("t3_short", sh, 1);
    chk("t3_rem", rm, 5);
    chk("t3_cnt25", o_n25, 7);
    use2 = 1'b0;

    do_reset();
    run_req(7, seq, lat, sh, rm);
    chk("t4_seq", seq, 32'h05);
    chk("t4_short", sh, 1);
    chk("t4_rem", rm, 2);
    chk("t4_cnt5", a_n5, 7);

    do_reset();
    coin_ack = 1'b0;
    @(negedge clk) req_valid = 1'b1; req_amount = 7'd25;
    @(negedge clk) req_amount = 7'd99;
    @(negedge clk);
    chk("t5_coin_up", a_c25, 1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("t5_busy_ready", a_ready, 0);
    chk("t5_held", {a_c25, a_c10, a_c5}, 3'b100);
    chk("t5_cnt_hold", a_n25, 8);
    req_valid = 1'b0;
    coin_ack = 1'b1;
    refill_25 = 1'b1;
    @(negedge clk);
    refill_25 = 1'b0;
    chk("t5_coin_down", a_c25, 0);
    chk("t5_refill_net0", a_n25, 8);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("t5_idle_ignored", {a_ready, a_c25, a_c10, a_c5}, 4'b1000);
    chk("t5_no_extra", {a_n25, a_n10, a_n5}, {6'd8, 6'd8, 6'd8});
    refill_10 = 1'b1;
    for (int i = 0; i < 64; i++) @(negedge clk);
    refill_10 = 1'b0;
    chk("t5_saturate", a_n10, 63);

    coin_ack = 1'b0;
    @(negedge clk) req_valid = 1'b1; req_amount = 7'd25;
    @(negedge clk) req_valid = 1'b0;
    @(negedge clk);
    chk("t6_issue", a_c25, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_coins", {a_c25, a_c10, a_c5}, 0);
    chk("t6_rst_ready", a_ready, 1);
    chk("t6_rst_cnt", {a_n25, a_n10, a_n5}, {6'd8, 6'd8, 6'd8});
    @(negedge clk) reset_n = 1'b1;
    coin_ack = 1'b1;
    run_req(10, seq, lat, sh, rm);
    chk("t6_seq", seq, 32'h0a);
    chk("t6_lat", lat, 3);
    chk("t6_short", sh, 0);
    chk("t6_cnt10", a_n10, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
